// File: rtl/queue_alt_split_if.sv
// ============================================================================
// Module   : queue_alt_split_if
// Purpose  : valid/ready/data stream interface used by queue_alt_split.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface queue_alt_split_if #(
  parameter int W = 16
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport producer (output valid, output data, input  ready);
  modport consumer (input  valid, input  data, output ready);
  modport master   (output valid, output data, input  ready);
  modport slave    (input  valid, input  data, output ready);
endinterface

`default_nettype wire

// File: rtl/queue_alt_split.sv
// ============================================================================
// Module   : queue_alt_split
// Purpose  : Alternates eot-terminated queues from din between dout0/dout1.
//            Define QUEUE_ALT_SPLIT_SKID_EN for a 1-entry registered output
//            stage per port; otherwise the data path is combinational.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module queue_alt_split #(
  parameter int W_DATA = 16
) (
  input  logic                clk,
  input  logic                rst,
  queue_alt_split_if.consumer din,
  queue_alt_split_if.consumer trig_in,
  queue_alt_split_if.producer dout0,
  queue_alt_split_if.producer dout1
);

  localparam logic [0:0] ROUTE0 = 1'b0;
  localparam logic [0:0] ROUTE1 = 1'b1;

  logic [0:0] sel_q;
  logic [0:0] sel_d;
  logic       w_din_hs;
  logic       w_eot;
  logic       w_trig_clr;

  assign w_din_hs   = din.valid && din.ready;
  assign w_eot      = din.data[W_DATA-1];
  assign w_trig_clr = trig_in.valid && !trig_in.data[0];
  assign trig_in.ready = 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_q <= ROUTE0;
    end else begin
      sel_q <= sel_d;
    end
  end

  // A restart request outranks the queue-boundary toggle.
  always_comb begin
    sel_d = sel_q;
    if (w_trig_clr) begin
      sel_d = ROUTE0;
    end else if (w_din_hs && w_eot) begin
      sel_d = (sel_q == ROUTE0) ? ROUTE1 : ROUTE0;
    end
  end

`ifdef QUEUE_ALT_SPLIT_SKID_EN
  logic              full0_q;
  logic              full0_d;
  logic              full1_q;
  logic              full1_d;
  logic [W_DATA-1:0] data0_q;
  logic [W_DATA-1:0] data0_d;
  logic [W_DATA-1:0] data1_q;
  logic [W_DATA-1:0] data1_d;
  logic              w_load0;
  logic              w_load1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full0_q <= 1'b0;
      full1_q <= 1'b0;
      data0_q <= '0;
      data1_q <= '0;
    end else begin
      full0_q <= full0_d;
      full1_q <= full1_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
    end
  end

  // Each buffer may drain and refill on the same edge, giving 1 beat/cycle.
  always_comb begin
    w_load0 = w_din_hs && (sel_q == ROUTE0);
    w_load1 = w_din_hs && (sel_q == ROUTE1);
    full0_d = w_load0 || (full0_q && !dout0.ready);
    full1_d = w_load1 || (full1_q && !dout1.ready);
    data0_d = w_load0 ? din.data : data0_q;
    data1_d = w_load1 ? din.data : data1_q;
  end

  always_comb begin
    dout0.valid = full0_q;
    dout0.data  = data0_q;
    dout1.valid = full1_q;
    dout1.data  = data1_q;
    din.ready   = (sel_q == ROUTE0) ? (!full0_q || dout0.ready)
                                    : (!full1_q || dout1.ready);
  end
`else
  // Valid is gated by rst so both outputs stay quiet while reset is held.
  always_comb begin
    dout0.valid = din.valid && rst && (sel_q == ROUTE0);
    dout1.valid = din.valid && rst && (sel_q == ROUTE1);
    dout0.data  = din.data;
    dout1.data  = din.data;
    din.ready   = (sel_q == ROUTE0) ? dout0.ready : dout1.ready;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_queue_alt_split.sv
// ============================================================================
// Module   : tb_queue_alt_split
// Purpose  : Directed self-checking bench for queue_alt_split (both builds).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_queue_alt_split;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] e0[$];
  logic [15:0] e1[$];

  queue_alt_split_if #(.W(16)) din_if ();
  queue_alt_split_if #(.W(1))  trig_if ();
  queue_alt_split_if #(.W(16)) d0_if ();
  queue_alt_split_if #(.W(16)) d1_if ();

  queue_alt_split #(.W_DATA(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .din     (din_if),
    .trig_in (trig_if),
    .dout0   (d0_if),
    .dout1   (d1_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst && d0_if.valid && d0_if.ready) q0.push_back(d0_if.data);
    if (rst && d1_if.valid && d1_if.ready) q1.push_back(d1_if.data);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp(input string tag, input logic [15:0] got[$], input logic [15:0] exp[$]);
    chk({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      chk(tag, (i < got.size()) ? {16'h0, got[i]} : 32'hxxxx_xxxx, {16'h0, exp[i]});
    end
  endtask

  task automatic send(input logic [14:0] d, input logic e);
    int n;
    din_if.valid = 1'b1;
    din_if.data  = {e, d};
    #1;
    n = 0;
    while (!din_if.ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("send_ready", (n < 50), 1);
    @(posedge clk); #1;
  endtask

  task automatic trig_pulse(input logic v);
    trig_if.valid = 1'b1;
    trig_if.data  = v;
    @(posedge clk); #1;
    trig_if.valid = 1'b0;
  endtask

  task automatic drain();
    din_if.valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [14:0] pd;
    logic        pe;
    int          j;
    int          dst;

    rst           = 1'b0;
    din_if.valid  = 1'b1;
    din_if.data   = 16'h8001;
    trig_if.valid = 1'b0;
    trig_if.data  = 1'b0;
    d0_if.ready   = 1'b1;
    d1_if.ready   = 1'b1;
    #2;
    chk("rst_d0_valid", d0_if.valid, 0);
    chk("rst_d1_valid", d1_if.valid, 0);
    chk("rst_din_ready", din_if.ready, 1);
    din_if.valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Three queues with both outputs ready.
    send(1, 0); send(2, 0); send(3, 1);
    send(4, 0); send(5, 1);
    send(6, 1);
    drain();
    e0 = '{16'h0001, 16'h0002, 16'h8003, 16'h8006};
    e1 = '{16'h0004, 16'h8005};
    cmp("abc_d0", q0, e0);
    cmp("abc_d1", q1, e1);

    // dout1 backpressure while queue B is presented.
    trig_pulse(1'b0);
    q0.delete(); q1.delete();
    send(1, 0); send(2, 0); send(3, 1);
    d1_if.ready  = 1'b0;
    din_if.valid = 1'b1;
    din_if.data  = 16'h0004;
    #1;
`ifdef QUEUE_ALT_SPLIT_SKID_EN
    chk("stall_fill_ready", din_if.ready, 1);
    @(posedge clk); #1;
    din_if.data = 16'h8005;
    #1;
`endif
    for (int k = 0; k < 5; k++) begin
      chk("stall_ready", din_if.ready, 0);
      chk("stall_d0_valid", d0_if.valid, 0);
      @(posedge clk); #1;
    end
    d1_if.ready = 1'b1;
`ifndef QUEUE_ALT_SPLIT_SKID_EN
    send(4, 0);
`endif
    send(5, 1);
    drain();
    e0 = '{16'h0001, 16'h0002, 16'h8003};
    e1 = '{16'h0004, 16'h8005};
    cmp("stall_d0", q0, e0);
    cmp("stall_d1", q1, e1);

    // Mid-queue restart: data=0 takes effect, data=1 is ignored.
    q0.delete(); q1.delete();
    send(7, 1);
    send(4, 0);
    din_if.valid = 1'b0;
    trig_pulse(1'b0);
    send(5, 1);
    send(4, 0);
    din_if.valid = 1'b0;
    trig_pulse(1'b1);
    send(5, 1);
    drain();
    e0 = '{16'h8007, 16'h8005};
    e1 = '{16'h0004, 16'h0004, 16'h8005};
    cmp("trig_d0", q0, e0);
    cmp("trig_d1", q1, e1);

    // Restart coincident with an eot handshake wins over the toggle.
    q0.delete(); q1.delete();
    send(1, 0); send(2, 0);
    trig_if.valid = 1'b1;
    trig_if.data  = 1'b0;
    send(3, 1);
    trig_if.valid = 1'b0;
    send(9, 1);
    drain();
    e0 = '{16'h0001, 16'h0002, 16'h8003, 16'h8009};
    e1.delete();
    cmp("coinc_d0", q0, e0);
    cmp("coinc_d1", q1, e1);
    chk("trig_ready", trig_if.ready, 1);

    // Asynchronous reset mid-queue with a beat waiting on dout1.
    q0.delete(); q1.delete();
    d1_if.ready  = 1'b0;
    din_if.valid = 1'b1;
    din_if.data  = 16'h0004;
    @(posedge clk); #2;
    chk("arst_pre_d1_valid", d1_if.valid, 1);
    chk("arst_pre_d0_valid", d0_if.valid, 0);
    #1;
    din_if.valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("arst_d1_valid", d1_if.valid, 0);
    chk("arst_d0_valid", d0_if.valid, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    d1_if.ready = 1'b1;
    send(5, 1);
    drain();
    e0 = '{16'h8005};
    e1.delete();
    cmp("arst_d0", q0, e0);
    cmp("arst_d1", q1, e1);

    // 100 back-to-back beats, eot on every 7th, both outputs ready.
    trig_pulse(1'b0);
    for (int i = 0; i <= 100; i++) begin
      if (i < 100) begin
        pd = 15'(i + 256);
        pe = ((i % 7) == 6);
        din_if.valid = 1'b1;
        din_if.data  = {pe, pd};
      end else begin
        din_if.valid = 1'b0;
      end
      #1;
`ifdef QUEUE_ALT_SPLIT_SKID_EN
      j = i - 1;
`else
      j = i;
`endif
      if (i < 100) chk("burst_ready", din_if.ready, 1);
      if (j >= 0 && j < 100) begin
        dst = (j / 7) % 2;
        chk("burst_out",
            {14'h0, d0_if.valid, d1_if.valid, (dst == 1) ? d1_if.data : d0_if.data},
            {14'h0, (dst == 0), (dst == 1), ((j % 7) == 6), 15'(j + 256)});
      end
      @(posedge clk); #1;
    end
    din_if.valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/queue_alt_split.md
QUEUE_ALT_SPLIT -- requirements
Module: queue_alt_split

Interface
REQ-001 SHALL have parameter W_DATA, default 16: total payload width; bit W_DATA-1 is eot, bits W_DATA-2:0 are data.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port din  dti.consumer  W_DATA  single stream carrying queues back to back, each queue terminated by eot=1.
REQ-005 SHALL have port trig_in  dti.consumer  1  routing-restart request; data=0 with valid=1 forces routing back to dout0.
REQ-006 SHALL have port dout0  dti.producer  W_DATA  receives even-numbered queues (0, 2, 4, ...).
REQ-007 SHALL have port dout1  dti.producer  W_DATA  receives odd-numbered queues (1, 3, 5, ...).

Function
REQ-008 SHALL hold one state bit sel with states ROUTE0 (sel=0) and ROUTE1 (sel=1).
REQ-009 SHALL steer every din transfer to dout0 in ROUTE0 and to dout1 in ROUTE1, with payload including eot unmodified.
REQ-010 SHALL toggle sel only on a completed din handshake (din.valid and din.ready) with eot=1; a valid eot without ready SHALL NOT toggle.
REQ-011 SHALL tie trig_in.ready to 1.
REQ-012 SHALL, on trig_in.valid=1 with trig_in.data=0, set sel to ROUTE0 on the next edge; trig_in.data=1 SHALL have no effect.
REQ-013 SHALL give trig priority when a trig and an eot handshake occur in the same cycle: next sel=ROUTE0.
REQ-014 SHALL keep the non-selected output's valid at 0 for all new data; only buffered data already committed to it may remain valid (REQ-017).
REQ-015 SHALL never reorder, duplicate or drop a din beat; a beat's destination is fixed by sel in the cycle it is accepted.
REQ-016 SHALL deassert din.ready whenever the selected output cannot accept (see REQ-017/REQ-018).

Reset
REQ-019 SHALL, while rst=0, force sel=ROUTE0, dout0.valid=0, dout1.valid=0, and clear all buffer-full flags, independent of clk.
REQ-020 SHALL leave din.ready combinational from the cleared state during reset; no transfer completes on the release edge unless it is a legal handshake.
REQ-021 SHALL discard buffered beats on reset assertion mid-queue; after release, the next beat goes to dout0.

Configuration
REQ-022 SHALL use macro QUEUE_ALT_SPLIT_SKID_EN to select the output stage.
REQ-017 With QUEUE_ALT_SPLIT_SKID_EN defined: each output has a 1-entry register (data plus full flag); accepted beat appears on its dout next cycle (latency 1); din.ready = !full_sel || dout_sel.ready; a buffer SHALL fill and drain in the same cycle when its dout handshakes; full-throughput 1 beat/cycle sustained when dout ready is held high; after a switch, the previous output's buffer SHALL still drain normally.
REQ-018 Without the macro: purely combinational data path, latency 0; dout_sel.valid = din.valid, din.ready = dout_sel.ready, dout_sel.data = din.data; only sel is registered.
REQ-023 SHALL keep identical port list, routing and trig semantics in both builds.

Verification
REQ-024 Reset then queues A=[1,2,3(eot)], B=[4,5(eot)], C=[6(eot)] with both outs ready -> dout0 gets 1,2,3,6; dout1 gets 4,5; eot on 3,5,6.
REQ-025 dout1.ready=0 for 5 cycles while queue B is presented -> din.ready=0 (after 1-entry fill when SKID_EN), no beat on dout0, B delivered intact after ready rises.
REQ-026 Mid-queue B (after beat 4) trig_in valid data=0 -> sel=ROUTE0; beat 5 goes to dout0; data=1 in same position -> no change, beat 5 to dout1.
REQ-027 eot handshake of A coincident with trig data=0 -> next queue routes to dout0, not dout1.
REQ-028 Assert rst=0 asynchronously (between edges) during queue B with SKID_EN -> both valids drop immediately, buffered beat lost, next beat after release goes to dout0.
REQ-029 SKID_EN, both outputs always ready, 100 back-to-back beats with eot every 7 -> one beat per cycle on the appropriate output, latency exactly 1 cycle, no bubbles.
